// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: widths, instruction fields,
// opcode map, FSM states and the opcode legality check.
package alu_pkg;

   localparam int DATA_W  = 19;
   localparam int IMM_W   = 10;
   localparam int NREGS   = 8;
   localparam int ADDR_W  = 3;
   localparam int OPC_W   = 5;
   localparam int INSTR_W = 24;

   localparam int OPC_HI = 23;
   localparam int OPC_LO = 19;
   localparam int RD_HI  = 18;
   localparam int RD_LO  = 16;
   localparam int RS1_HI = 15;
   localparam int RS1_LO = 13;
   localparam int RS2_HI = 12;
   localparam int RS2_LO = 10;
   localparam int IMM_HI = 9;
   localparam int IMM_LO = 0;

   localparam logic [4:0] OP_ADD   = 5'b00000;
   localparam logic [4:0] OP_SUB   = 5'b00001;
   localparam logic [4:0] OP_MUL   = 5'b00010;
   localparam logic [4:0] OP_DIV   = 5'b00011;
   localparam logic [4:0] OP_MOD   = 5'b00100;
   localparam logic [4:0] OP_AND   = 5'b00101;
   localparam logic [4:0] OP_OR    = 5'b00110;
   localparam logic [4:0] OP_XOR   = 5'b00111;
   localparam logic [4:0] OP_MAC   = 5'b01000;
   localparam logic [4:0] OP_SHL   = 5'b01001;
   localparam logic [4:0] OP_SHR   = 5'b01010;
   localparam logic [4:0] OP_ADDI  = 5'b01011;
   localparam logic [4:0] OP_ANDI  = 5'b01100;
   localparam logic [4:0] OP_ORI   = 5'b01101;
   localparam logic [4:0] OP_UNDEF = 5'b01110;
   localparam logic [4:0] OP_BEQ   = 5'b01111;
   localparam logic [4:0] OP_BNE   = 5'b10000;
   localparam logic [4:0] OP_NOT   = 5'b10001;
   localparam logic [4:0] OP_SLT   = 5'b10010;
   localparam logic [4:0] OP_SUBI  = 5'b10011;
   localparam logic [4:0] OP_XORI  = 5'b10100;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   function automatic logic is_legal_op(input logic [4:0] op);
      logic legal_s;
      case (op)
         OP_UNDEF: legal_s = 1'b0;
         default:  legal_s = (op <= OP_XORI);
      endcase
      return legal_s;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file: two async read ports, a debug read port and one
// synchronous write port; r0 is hardwired to zero.
module alu_regfile
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] mem_r [NREGS];

   // register storage with async clear; writes to r0 are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (we && (waddr != 3'd0)) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata1   = (raddr1   == 3'd0) ? {DATA_W{1'b0}} : mem_r[raddr1];
   assign rdata2   = (raddr2   == 3'd0) ? {DATA_W{1'b0}} : mem_r[raddr2];
   assign dbg_data = (dbg_addr == 3'd0) ? {DATA_W{1'b0}} : mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the 19-bit ALU: accepts an instruction, reads
// operands, drives the ALU, then writes back or flags branch/error outcomes.
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [INSTR_W-1:0]  instr,
   output logic [OPC_W-1:0]    alu_opcode,
   output logic [DATA_W-1:0]   alu_op1,
   output logic [DATA_W-1:0]   alu_op2,
   output logic [IMM_W-1:0]    alu_immediate,
   input  logic [DATA_W-1:0]   alu_result,
   output logic                wb_valid,
   output logic [ADDR_W-1:0]   wb_addr,
   output logic [DATA_W-1:0]   wb_data,
   output logic                branch_taken,
   output logic [IMM_W-1:0]    branch_target,
   output logic                illegal_op,
   output logic                div_by_zero,
   output logic                busy,
   input  logic [ADDR_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0]   dbg_data
);

   state_t               state_r;
   logic [INSTR_W-1:0]   instr_r;
   logic                 ready_r;
   logic                 busy_r;
   logic [OPC_W-1:0]     alu_opcode_r;
   logic [DATA_W-1:0]    alu_op1_r;
   logic [DATA_W-1:0]    alu_op2_r;
   logic [IMM_W-1:0]     alu_imm_r;
   logic                 wb_valid_r;
   logic [ADDR_W-1:0]    wb_addr_r;
   logic [DATA_W-1:0]    wb_data_r;
   logic                 branch_taken_r;
   logic [IMM_W-1:0]     branch_target_r;
   logic                 illegal_r;
   logic                 dbz_r;

   logic [OPC_W-1:0]     opc_s;
   logic [ADDR_W-1:0]    rd_s;
   logic [ADDR_W-1:0]    rs1_s;
   logic [ADDR_W-1:0]    rs2_s;
   logic [IMM_W-1:0]     imm_s;
   logic [ADDR_W-1:0]    raddr1_s;
   logic [DATA_W-1:0]    rdata1_s;
   logic [DATA_W-1:0]    rdata2_s;
   logic                 we_s;

   assign opc_s = instr_r[OPC_HI:OPC_LO];
   assign rd_s  = instr_r[RD_HI:RD_LO];
   assign rs1_s = instr_r[RS1_HI:RS1_LO];
   assign rs2_s = instr_r[RS2_HI:RS2_LO];
   assign imm_s = instr_r[IMM_HI:IMM_LO];

   // port 1 fetches rs1 in READ and the old rd value (for MAC) in EXEC
   always_comb begin
      raddr1_s = rs1_s;
      if (state_r == EXEC) begin
         raddr1_s = rd_s;
      end else begin
         raddr1_s = rs1_s;
      end
   end

   assign we_s = (state_r == WB) && wb_valid_r;

   alu_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we_s),
      .waddr    (wb_addr_r),
      .wdata    (wb_data_r),
      .raddr1   (raddr1_s),
      .rdata1   (rdata1_s),
      .raddr2   (rs2_s),
      .rdata2   (rdata2_s),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // issue FSM with all outputs registered; WB outcome pulses last one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= IDLE;
         instr_r         <= {INSTR_W{1'b0}};
         ready_r         <= 1'b1;
         busy_r          <= 1'b0;
         alu_opcode_r    <= {OPC_W{1'b0}};
         alu_op1_r       <= {DATA_W{1'b0}};
         alu_op2_r       <= {DATA_W{1'b0}};
         alu_imm_r       <= {IMM_W{1'b0}};
         wb_valid_r      <= 1'b0;
         wb_addr_r       <= {ADDR_W{1'b0}};
         wb_data_r       <= {DATA_W{1'b0}};
         branch_taken_r  <= 1'b0;
         branch_target_r <= {IMM_W{1'b0}};
         illegal_r       <= 1'b0;
         dbz_r           <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (instr_valid && ready_r) begin
                  instr_r <= instr;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
                  state_r <= READ;
               end
            end
            READ: begin
               alu_op1_r    <= rdata1_s;
               alu_op2_r    <= rdata2_s;
               alu_imm_r    <= imm_s;
               alu_opcode_r <= (opc_s == OP_MAC) ? OP_MUL : opc_s;
               state_r      <= EXEC;
            end
            EXEC: begin
               if (!is_legal_op(opc_s)) begin
                  illegal_r <= 1'b1;
               end else if ((opc_s == OP_BEQ) || (opc_s == OP_BNE)) begin
                  if (alu_result[0]) begin
                     branch_taken_r  <= 1'b1;
                     branch_target_r <= imm_s;
                  end
               end else begin
                  wb_valid_r <= 1'b1;
                  wb_addr_r  <= rd_s;
                  if (opc_s == OP_MAC) begin
                     wb_data_r <= rdata1_s + alu_result;
                  end else if ((opc_s == OP_DIV) && (alu_op2_r == 19'd0)) begin
                     dbz_r     <= 1'b1;
                     wb_data_r <= 19'h7FFFF;
                  end else begin
                     wb_data_r <= alu_result;
                  end
               end
               state_r <= WB;
            end
            WB: begin
               wb_valid_r     <= 1'b0;
               branch_taken_r <= 1'b0;
               illegal_r      <= 1'b0;
               dbz_r          <= 1'b0;
               ready_r        <= 1'b1;
               busy_r         <= 1'b0;
               state_r        <= IDLE;
            end
            default: begin
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign instr_ready   = ready_r;
   assign busy          = busy_r;
   assign alu_opcode    = alu_opcode_r;
   assign alu_op1       = alu_op1_r;
   assign alu_op2       = alu_op2_r;
   assign alu_immediate = alu_imm_r;
   assign wb_valid      = wb_valid_r;
   assign wb_addr       = wb_addr_r;
   assign wb_data       = wb_data_r;
   assign branch_taken  = branch_taken_r;
   assign branch_target = branch_target_r;
   assign illegal_op    = illegal_r;
   assign div_by_zero   = dbz_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: hosts a behavioural ALU, drives directed and
// random instructions, and checks every outcome against an ISA-level model.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [23:0] instr;
   logic [4:0]  alu_opcode;
   logic [18:0] alu_op1;
   logic [18:0] alu_op2;
   logic [9:0]  alu_immediate;
   logic [18:0] alu_result;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [18:0] wb_data;
   logic        branch_taken;
   logic [9:0]  branch_target;
   logic        illegal_op;
   logic        div_by_zero;
   logic        busy;
   logic [2:0]  dbg_addr;
   logic [18:0] dbg_data;

   int tests = 0;
   int fails = 0;
   logic [18:0] regs [8];

   alu_issue_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .alu_opcode    (alu_opcode),
      .alu_op1       (alu_op1),
      .alu_op2       (alu_op2),
      .alu_immediate (alu_immediate),
      .alu_result    (alu_result),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .illegal_op    (illegal_op),
      .div_by_zero   (div_by_zero),
      .busy          (busy),
      .dbg_addr      (dbg_addr),
      .dbg_data      (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU semantics (immediate zero-extended by this bench's ALU)
   function automatic logic [18:0] alu_fn(input logic [4:0] op, input logic [18:0] a,
                                          input logic [18:0] b, input logic [9:0] imm);
      logic [18:0] i19;
      i19 = {9'd0, imm};
      case (op)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a * b;
         5'd3:  return (b == 19'd0) ? 19'd0 : a / b;
         5'd4:  return (b == 19'd0) ? 19'd0 : a % b;
         5'd5:  return a & b;
         5'd6:  return a | b;
         5'd7:  return a ^ b;
         5'd9:  return a << b[4:0];
         5'd10: return a >> b[4:0];
         5'd11: return a + i19;
         5'd12: return a & i19;
         5'd13: return a | i19;
         5'd15: return {18'd0, a == b};
         5'd16: return {18'd0, a != b};
         5'd17: return ~a;
         5'd18: return {18'd0, a < b};
         5'd19: return a - i19;
         5'd20: return a ^ i19;
         default: return 19'd0;
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_opcode, alu_op1, alu_op2, alu_immediate);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_dbg(input logic [2:0] a, input logic [18:0] exp);
      dbg_addr = a;
      #1;
      check("dbg_data", {13'd0, dbg_data}, {13'd0, exp});
   endtask

   task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [9:0] imm);
      logic [18:0] a, b, exp, r;
      logic legal, br, wr, dbz, taken;
      int n;
      a = (rs1 == 3'd0) ? 19'd0 : regs[rs1];
      b = (rs2 == 3'd0) ? 19'd0 : regs[rs2];
      legal = !((op == 5'd14) || (op > 5'd20));
      br    = (op == 5'd15) || (op == 5'd16);
      wr    = legal && !br;
      dbz   = (op == 5'd3) && (b == 19'd0);
      r     = alu_fn(op, a, b, imm);
      taken = br && r[0];
      if (op == 5'd8)
         exp = regs[rd] + alu_fn(5'd2, a, b, imm);
      else if (dbz)
         exp = 19'h7FFFF;
      else
         exp = r;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", {31'd0, instr_ready}, 32'd1);
      instr = {op, rd, rs1, rs2, imm};
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("busy_read", {31'd0, busy}, 32'd1);
            check("ready_read", {31'd0, instr_ready}, 32'd0);
            check("wbv_read", {31'd0, wb_valid}, 32'd0);
         end else if (k == 2) begin
            check("alu_opcode", {27'd0, alu_opcode}, {27'd0, (op == 5'd8) ? 5'd2 : op});
            check("alu_op1", {13'd0, alu_op1}, {13'd0, a});
            check("alu_op2", {13'd0, alu_op2}, {13'd0, b});
            check("alu_imm", {22'd0, alu_immediate}, {22'd0, imm});
         end else if (k == 3) begin
            check("wb_valid", {31'd0, wb_valid}, {31'd0, wr});
            check("illegal_op", {31'd0, illegal_op}, {31'd0, !legal});
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, dbz});
            check("branch_taken", {31'd0, branch_taken}, {31'd0, taken});
            if (wr) begin
               check("wb_addr", {29'd0, wb_addr}, {29'd0, rd});
               check("wb_data", {13'd0, wb_data}, {13'd0, exp});
            end
            if (taken) check("branch_target", {22'd0, branch_target}, {22'd0, imm});
         end else begin
            if (wr && rd != 3'd0) regs[rd] = exp;
            check("busy_idle", {31'd0, busy}, 32'd0);
            check("ready_idle", {31'd0, instr_ready}, 32'd1);
            check("pulse_end", {28'd0, wb_valid, illegal_op, div_by_zero, branch_taken}, 32'd0);
            check_dbg(rd, regs[rd]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, pulses, wbs;
      for (int i = 0; i < 8; i++) regs[i] = 19'd0;
      rst_n = 1'b0;
      instr_valid = 1'b0;
      instr = 24'd0;
      dbg_addr = 3'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset state
      check("rst_ready", {31'd0, instr_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_alu", {alu_opcode, alu_op1[8:0], alu_immediate, 8'd0}, 32'd0);
      check("rst_op1", {13'd0, alu_op1}, 32'd0);
      check("rst_op2", {13'd0, alu_op2}, 32'd0);
      check("rst_wb", {12'd0, wb_valid, wb_addr, wb_data[15:0]}, 32'd0);
      check("rst_flags", {19'd0, branch_taken, illegal_op, div_by_zero, branch_target}, 32'd0);
      for (int i = 0; i < 8; i++) check_dbg(i[2:0], 19'd0);

      // directed sequence
      issue(5'd11, 3'd1, 3'd0, 3'd0, 10'h005);
      check_dbg(3'd1, 19'd5);
      issue(5'd11, 3'd2, 3'd0, 3'd0, 10'h003);
      issue(5'd0, 3'd3, 3'd1, 3'd2, 10'h000);
      check_dbg(3'd3, 19'd8);
      issue(5'd8, 3'd3, 3'd1, 3'd2, 10'h000);
      check_dbg(3'd3, 19'd23);
      issue(5'd3, 3'd4, 3'd1, 3'd0, 10'h000);
      check_dbg(3'd4, 19'h7FFFF);
      issue(5'd1, 3'd5, 3'd0, 3'd1, 10'h000);
      check_dbg(3'd5, 19'h7FFFB);
      issue(5'd15, 3'd6, 3'd1, 3'd1, 10'h02A);
      issue(5'd16, 3'd6, 3'd1, 3'd1, 10'h02A);
      issue(5'd14, 3'd6, 3'd1, 3'd2, 10'h000);
      issue(5'd31, 3'd7, 3'd1, 3'd2, 10'h000);
      issue(5'd0, 3'd0, 3'd1, 3'd2, 10'h000);
      check_dbg(3'd0, 19'd0);

      // valid held high through busy: one accept every 4 cycles
      instr = {5'd14, 3'd6, 3'd1, 3'd2, 10'd0};
      instr_valid = 1'b1;
      acc = 0; pulses = 0; wbs = 0;
      for (int i = 0; i < 12; i++) begin
         if (instr_ready) acc++;
         if (illegal_op) pulses++;
         if (wb_valid) wbs++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      check("held_accepts", acc, 32'd3);
      check("held_illegal", pulses, 32'd3);
      check("held_writes", wbs, 32'd0);
      check_dbg(3'd6, regs[6]);

      // reset during EXEC of ADD r6
      instr = {5'd0, 3'd6, 3'd1, 3'd2, 10'd0};
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) regs[i] = 19'd0;
      check("mid_rst_wbv", {31'd0, wb_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
      for (int i = 0; i < 8; i++) check_dbg(i[2:0], 19'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wbs = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (wb_valid || illegal_op || branch_taken || div_by_zero) wbs++;
      end
      check("post_rst_pulses", wbs, 32'd0);
      check("post_rst_ready", {31'd0, instr_ready}, 32'd1);

      // random phase: seed registers then random opcodes
      for (int i = 1; i < 8; i++)
         issue(5'd11, i[2:0], 3'd0, 3'd0, 10'($urandom_range(0, 1023)));
      for (int i = 0; i < 60; i++)
         issue(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)));
      for (int i = 0; i < 8; i++) check_dbg(i[2:0], regs[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
